butterfly_r2_shared: RTL and testbench
======================================

Name: butterfly_r2_shared

Overview:
- Parametrised, handshaked successor to the fixed-function shared DIT butterfly.
- Computes one radix-2 complex butterfly every 2 cycles using 2 time-shared real multipliers.
- Supports DIT and DIF modes, forward/inverse (conjugate twiddle), optional per-stage scale-by-½, twiddle-product rounding, saturation and an overflow flag.
- Sits between the FFT stage memory/address generator and the stage write-back path.

Parameters:
- DATA_WIDTH, 32, width of each real/imag data component (signed two's complement).
- FACTOR_WIDTH, 16, width of each real/imag twiddle component (signed).
- FRAC_BITS, 14, twiddle fraction bits (1.0 = 2^FRAC_BITS); must be < FACTOR_WIDTH.
- ROUND, 1, 1 = round-half-up on twiddle products (add 2^(FRAC_BITS-1) before truncation); 0 = truncate.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input butterfly present
- in_ready  output  1  block can accept this cycle
- in_x0  input  2*DATA_WIDTH  {re, im}
- in_x1  input  2*DATA_WIDTH  {re, im}
- in_w  input  2*FACTOR_WIDTH  twiddle {re, im}
- in_mode_dif  input  1  0 = DIT, 1 = DIF
- in_inverse  input  1  1 = use conj(w)
- in_scale  input  1  1 = arithmetic shift right by 1 on both outputs
- out_valid  output  1  result valid (single-cycle pulse)
- out_x0  output  2*DATA_WIDTH  {re, im}
- out_x1  output  2*DATA_WIDTH  {re, im}
- out_ovf  output  1  any component saturated in this result; valid with out_valid

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset: out_valid=0, out_ovf=0, out_x0=0, out_x1=0, in_ready=1. All pipeline valids cleared. In-flight results are discarded; none emerge after reset.
- Accept: occurs on an edge where in_valid && in_ready. in_x0, in_x1, in_w, in_mode_dif, in_inverse and in_scale are all captured at that edge and fixed for that transaction.
- in_ready: deasserts for exactly 1 cycle after each accept, otherwise 1. This gives a maximum throughput of 1 butterfly per 2 cycles. in_valid is ignored while in_ready=0.
- No output backpressure: the result is presented with out_valid=1 for exactly 1 cycle, on the 4th rising edge after the accepting edge (latency 4). out_x0, out_x1 and out_ovf hold their values until the next result.
- Twiddle: w' = inverse ? (w_r, -w_i) : (w_r, w_i). Negating the most-negative w_i saturates to the max positive value.
- Complex multiply m = a*w':
  - m_r = a_r*w'_r - a_i*w'_i
  - m_i = a_r*w'_i + a_i*w'_r
  - Products are DATA_WIDTH+FACTOR_WIDTH wide, optionally rounded, then bits [DATA_WIDTH+FRAC_BITS-1:FRAC_BITS] are taken.
  - The product real and imag parts are computed in alternate cycles on the 2 shared multipliers.
- DIT: out0 = x0 + x1*w', out1 = x0 - x1*w'.
- DIF: out0 = x0 + x1, out1 = (x0 - x1)*w'. The difference is saturated to DATA_WIDTH before the multiply, and that saturation sets ovf.
- Add/sub: performed in DATA_WIDTH+1 bits.
  - If scale=1: arithmetic shift right 1 (floor) into DATA_WIDTH; no saturation is possible.
  - If scale=0: saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - DIF out1 (the product path) is not scaled.
- out_ovf: OR of every saturation event in the transaction.
- Throughput: back-to-back transactions with different modes are independent. No cross-contamination of mode or scale bits between transactions in flight.

Test Plan:
All tests use defaults (DATA_WIDTH=32, FACTOR_WIDTH=16, FRAC_BITS=14, ROUND=1); 1.0 = 16384.
- Basic DIT, unity twiddle: x0=(100,50), x1=(20,10), w=(16384,0), DIT, scale=0 -> out_x0=(120,60), out_x1=(80,40), ovf=0, out_valid exactly 4 edges after accept.
- DIT, -j twiddle: same x, w=(0,-16384) -> out_x0=(110,30), out_x1=(90,70). Repeat with w=(0,16384), inverse=1 -> identical result.
- DIF, -j twiddle: x0=(100,50), x1=(20,10), w=(0,-16384) -> out_x0=(120,60), out_x1=(40,-80).
- Saturation/scale: x0=(0x7FFFFFF0,0), x1=(0x20,0), w=(16384,0), DIT.
  - scale=0 -> out_x0.re=0x7FFFFFFF, ovf=1, out_x1.re=0x7FFFFFD0.
  - scale=1 -> out_x0.re=0x40000008, out_x1.re=0x3FFFFFE8, ovf=0.
- Streaming: in_valid held high for 8 cycles with alternating DIT/DIF transactions.
  - in_ready pattern 1,0,1,0,...; 4 accepts.
  - out_valid pulses every 2 cycles starting 4 edges after the first accept.
  - Each result matches its own mode.
- Reset mid-flight: accept 2 butterflies, assert rst for 1 cycle before either result emerges -> out_valid stays 0 and outputs=0. in_ready=1 on the cycle after reset. The next accept produces a correct result with latency 4.

Source files
------------

// File: rtl/butterfly_r2_shared_if.sv
// Handshake and payload bundle between the FFT stage address generator,
// the shared radix-2 butterfly and the stage write-back path.
interface butterfly_r2_shared_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FACTOR_WIDTH = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [2*DATA_WIDTH-1:0]   in_x0;
  logic [2*DATA_WIDTH-1:0]   in_x1;
  logic [2*FACTOR_WIDTH-1:0] in_w;
  logic                      in_mode_dif;
  logic                      in_inverse;
  logic                      in_scale;
  logic                      out_valid;
  logic [2*DATA_WIDTH-1:0]   out_x0;
  logic [2*DATA_WIDTH-1:0]   out_x1;
  logic                      out_ovf;

  modport master (
    output in_valid, in_x0, in_x1, in_w, in_mode_dif, in_inverse, in_scale,
    input  in_ready, out_valid, out_x0, out_x1, out_ovf
  );

  modport slave (
    input  in_valid, in_x0, in_x1, in_w, in_mode_dif, in_inverse, in_scale,
    output in_ready, out_valid, out_x0, out_x1, out_ovf
  );
endinterface

// File: rtl/butterfly_r2_shared.sv
// Radix-2 DIT/DIF complex butterfly, one result per 2 cycles, latency 4,
// using two real multipliers shared between the real and imaginary products.
module butterfly_r2_shared #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FACTOR_WIDTH = 16,
  parameter int unsigned FRAC_BITS    = 14,
  parameter int unsigned ROUND        = 1
) (
  input logic                  clk,
  input logic                  rst,
  butterfly_r2_shared_if.slave bus
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned FW = FACTOR_WIDTH;
  localparam int unsigned PW = DW + FW;
  localparam int unsigned SW = DW + 1;
  localparam logic signed [FW-1:0] W_MIN = {1'b1, {(FW-1){1'b0}}};
  localparam logic signed [FW-1:0] W_MAX = {1'b0, {(FW-1){1'b1}}};
  localparam logic signed [PW:0]   RND   = (ROUND != 0) ? ((PW+1)'(1) << (FRAC_BITS - 1)) : '0;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  function automatic logic signed [DW-1:0] sat_fn(input logic signed [SW-1:0] v);
    if (v[SW-1] != v[SW-2]) return v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] fin_fn(input logic signed [SW-1:0] v, input logic sc);
    if (sc) return v[SW-1:1];
    return sat_fn(v);
  endfunction

  function automatic logic ovf_fn(input logic signed [SW-1:0] v, input logic sc);
    return !sc && (v[SW-1] != v[SW-2]);
  endfunction

  state_t state, state_nx;
  logic   accept_c;

  // accept-edge operand preparation: twiddle conjugation and DIF difference
  logic signed [DW-1:0] x0r_c, x0i_c, x1r_c, x1i_c;
  logic signed [FW-1:0] wr_c, wi_c, wi_conj_c;
  logic signed [SW-1:0] dr_c, di_c;
  assign x0r_c     = bus.in_x0[2*DW-1:DW];
  assign x0i_c     = bus.in_x0[DW-1:0];
  assign x1r_c     = bus.in_x1[2*DW-1:DW];
  assign x1i_c     = bus.in_x1[DW-1:0];
  assign wr_c      = bus.in_w[2*FW-1:FW];
  assign wi_c      = bus.in_w[FW-1:0];
  assign wi_conj_c = (wi_c == W_MIN) ? W_MAX : -wi_c;
  assign dr_c      = SW'(x0r_c) - SW'(x1r_c);
  assign di_c      = SW'(x0i_c) - SW'(x1i_c);
  assign accept_c  = bus.in_valid && bus.in_ready;

  // stage A: multiplicand and context, held until the next accept
  logic signed [DW-1:0] ar_q, ai_q, ax0r_q, ax0i_q, ax1r_q, ax1i_q;
  logic signed [FW-1:0] wr_q, wi_q;
  logic                 adif_q, ascale_q, adovf_q;
  // stage B/C/D
  logic signed [PW-1:0] prr_q, pii_q;
  logic signed [DW-1:0] mr_q, mi_q, cx0r_q, cx0i_q, cx1r_q, cx1i_q;
  logic                 cdif_q, cscale_q, cdovf_q;
  logic signed [SW-1:0] s0r_q, s0i_q, s1r_q, s1i_q;
  logic                 sc0_q, sc1_q, ddovf_q;
  logic                 v2_q, v3_q, v4_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept_c) state_nx = ST_BUSY;
      ST_BUSY: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // shared multipliers: real-part products in BUSY, imaginary-part products in IDLE
  logic signed [FW-1:0] mb0_c, mb1_c;
  logic signed [PW-1:0] mul0_c, mul1_c;
  always_comb begin
    mb0_c = wr_q;
    mb1_c = wi_q;
    if (state == ST_IDLE) begin
      mb0_c = wi_q;
      mb1_c = wr_q;
    end
  end
  assign mul0_c = PW'(ar_q) * PW'(mb0_c);
  assign mul1_c = PW'(ai_q) * PW'(mb1_c);

  logic signed [PW:0] mr_full_c, mi_full_c;
  logic               unused_c;
  assign mr_full_c = (PW+1)'(prr_q) - (PW+1)'(pii_q) + RND;
  assign mi_full_c = (PW+1)'(mul0_c) + (PW+1)'(mul1_c) + RND;
  assign unused_c  = ^{mr_full_c, mi_full_c};

  always_ff @(posedge clk) begin
    if (accept_c) begin
      ar_q     <= bus.in_mode_dif ? sat_fn(dr_c) : x1r_c;
      ai_q     <= bus.in_mode_dif ? sat_fn(di_c) : x1i_c;
      wr_q     <= wr_c;
      wi_q     <= bus.in_inverse ? wi_conj_c : wi_c;
      ax0r_q   <= x0r_c;
      ax0i_q   <= x0i_c;
      ax1r_q   <= x1r_c;
      ax1i_q   <= x1i_c;
      adif_q   <= bus.in_mode_dif;
      ascale_q <= bus.in_scale;
      adovf_q  <= bus.in_mode_dif && (ovf_fn(dr_c, 1'b0) || ovf_fn(di_c, 1'b0));
    end
    if (state == ST_BUSY) begin
      prr_q <= mul0_c;
      pii_q <= mul1_c;
    end
    if (v2_q) begin
      mr_q     <= mr_full_c[DW+FRAC_BITS-1:FRAC_BITS];
      mi_q     <= mi_full_c[DW+FRAC_BITS-1:FRAC_BITS];
      cx0r_q   <= ax0r_q;
      cx0i_q   <= ax0i_q;
      cx1r_q   <= ax1r_q;
      cx1i_q   <= ax1i_q;
      cdif_q   <= adif_q;
      cscale_q <= ascale_q;
      cdovf_q  <= adovf_q;
    end
    if (v3_q) begin
      if (cdif_q) begin
        s0r_q <= SW'(cx0r_q) + SW'(cx1r_q);
        s0i_q <= SW'(cx0i_q) + SW'(cx1i_q);
        s1r_q <= SW'(mr_q);
        s1i_q <= SW'(mi_q);
      end else begin
        s0r_q <= SW'(cx0r_q) + SW'(mr_q);
        s0i_q <= SW'(cx0i_q) + SW'(mi_q);
        s1r_q <= SW'(cx0r_q) - SW'(mr_q);
        s1i_q <= SW'(cx0i_q) - SW'(mi_q);
      end
      sc0_q   <= cscale_q;
      sc1_q   <= cscale_q && !cdif_q;
      ddovf_q <= cdovf_q;
    end
  end

  // control valids and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready  <= 1'b1;
      v2_q          <= 1'b0;
      v3_q          <= 1'b0;
      v4_q          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_x0    <= '0;
      bus.out_x1    <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      bus.in_ready  <= (state_nx == ST_IDLE);
      v2_q          <= (state == ST_BUSY);
      v3_q          <= v2_q;
      v4_q          <= v3_q;
      bus.out_valid <= v4_q;
      if (v4_q) begin
        bus.out_x0  <= {fin_fn(s0r_q, sc0_q), fin_fn(s0i_q, sc0_q)};
        bus.out_x1  <= {fin_fn(s1r_q, sc1_q), fin_fn(s1i_q, sc1_q)};
        bus.out_ovf <= ddovf_q || ovf_fn(s0r_q, sc0_q) || ovf_fn(s0i_q, sc0_q)
                               || ovf_fn(s1r_q, sc1_q) || ovf_fn(s1i_q, sc1_q);
      end
    end
  end
endmodule

// File: tb/tb_butterfly_r2_shared.sv
// Bench for butterfly_r2_shared: directed plan cases, streaming, mid-flight
// reset and random traffic scored against an arithmetic reference model.
module tb_butterfly_r2_shared;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint RNDV = 64'sd8192;

  typedef struct {
    int          due;
    logic [63:0] x0;
    logic [63:0] x1;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   exp_ready;
  exp_t q[$];
  exp_t last;

  butterfly_r2_shared_if #(.DATA_WIDTH(DW), .FACTOR_WIDTH(FW)) bus ();
  butterfly_r2_shared #(.DATA_WIDTH(DW), .FACTOR_WIDTH(FW), .FRAC_BITS(14), .ROUND(1))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction
  function automatic longint sat32(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction
  function automatic bit oor32(input longint v);
    return (v > MAXV) || (v < MINV);
  endfunction
  function automatic longint twid(input longint p);
    longint t;
    logic [31:0] b;
    t = (p + RNDV) >>> 14;
    b = t[31:0];
    return s32(b);
  endfunction
  function automatic longint outv(input longint v, input bit sc);
    return sc ? (v >>> 1) : sat32(v);
  endfunction

  // plain complex arithmetic on 64-bit integers
  function automatic exp_t model(input logic [63:0] x0, input logic [63:0] x1,
                                 input logic [31:0] w, input bit dif, input bit inv, input bit sc);
    exp_t e;
    longint x0r, x0i, x1r, x1i, wr, wi, ar, ai, mr, mi, s0r, s0i, s1r, s1i;
    longint o0r, o0i, o1r, o1i;
    bit ovf;
    x0r = s32(x0[63:32]); x0i = s32(x0[31:0]);
    x1r = s32(x1[63:32]); x1i = s32(x1[31:0]);
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    if (inv) wi = (wi == -64'sd32768) ? 64'sd32767 : -wi;
    ovf = 1'b0;
    if (dif) begin
      ar  = sat32(x0r - x1r);
      ai  = sat32(x0i - x1i);
      ovf = oor32(x0r - x1r) || oor32(x0i - x1i);
    end else begin
      ar = x1r;
      ai = x1i;
    end
    mr = twid(ar * wr - ai * wi);
    mi = twid(ar * wi + ai * wr);
    if (dif) begin
      s0r = x0r + x1r; s0i = x0i + x1i;
      o0r = outv(s0r, sc); o0i = outv(s0i, sc);
      o1r = mr; o1i = mi;
      if (!sc) ovf = ovf || oor32(s0r) || oor32(s0i);
    end else begin
      s0r = x0r + mr; s0i = x0i + mi;
      s1r = x0r - mr; s1i = x0i - mi;
      o0r = outv(s0r, sc); o0i = outv(s0i, sc);
      o1r = outv(s1r, sc); o1i = outv(s1i, sc);
      if (!sc) ovf = ovf || oor32(s0r) || oor32(s0i) || oor32(s1r) || oor32(s1i);
    end
    e.due = 0;
    e.x0  = {o0r[31:0], o0i[31:0]};
    e.x1  = {o1r[31:0], o1i[31:0]};
    e.ovf = ovf;
    return e;
  endfunction

  // one clock: record an accept, step to the next falling edge, score outputs
  task automatic tick(output bit acc);
    exp_t e;
    bit   r, ev;
    r = rst;
    if (!r) chk("in_ready", bus.in_ready, exp_ready);
    acc = !r && bus.in_valid && bus.in_ready;
    if (acc) begin
      e = model(bus.in_x0, bus.in_x1, bus.in_w, bus.in_mode_dif, bus.in_inverse, bus.in_scale);
      e.due = cyc + 5;
      q.push_back(e);
    end
    @(negedge clk);
    cyc++;
    if (r) begin
      q.delete();
      last = '{0, 64'h0, 64'h0, 1'b0};
      exp_ready = 1'b1;
      chk("rst_valid", bus.out_valid, 1'b0);
    end else begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", bus.out_valid, ev);
      if (ev) last = q.pop_front();
      exp_ready = !acc;
    end
    chk("out_x0", bus.out_x0, last.x0);
    chk("out_x1", bus.out_x1, last.x1);
    chk("out_ovf", bus.out_ovf, last.ovf);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic load(input logic [63:0] x0, input logic [63:0] x1, input logic [31:0] w,
                      input bit dif, input bit inv, input bit sc);
    bus.in_x0 = x0; bus.in_x1 = x1; bus.in_w = w;
    bus.in_mode_dif = dif; bus.in_inverse = inv; bus.in_scale = sc;
  endtask

  task automatic send(input logic [63:0] x0, input logic [63:0] x1, input logic [31:0] w,
                      input bit dif, input bit inv, input bit sc);
    bit acc;
    int n;
    load(x0, x1, w, dif, inv, sc);
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      tick(acc);
      n++;
    end while (!acc && n < 8);
    chk("accept", acc, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rd();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = $urandom;
      1: t = 32'h7FFF_FFFF - 32'($urandom_range(0, 255));
      2: t = 32'h8000_0000 + 32'($urandom_range(0, 255));
      default: t = 32'($urandom_range(0, 2000)) - 32'd1000;
    endcase
    return t;
  endfunction

  function automatic logic [15:0] rw();
    logic [15:0] t;
    case ($urandom_range(0, 4))
      0: t = 16'h8000;
      1: t = 16'h4000;
      2: t = 16'hC000;
      default: t = 16'($urandom);
    endcase
    return t;
  endfunction

  task automatic load_rand(input bit dif);
    load({rd(), rd()}, {rd(), rd()}, {rw(), rw()}, dif, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    bit acc;
    int n_acc;
    bit md;
    rst = 1'b1;
    exp_ready = 1'b1;
    last = '{0, 64'h0, 64'h0, 1'b0};
    bus.in_valid = 1'b0;
    load('0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(2);

    // directed plan cases
    send({32'd100, 32'd50}, {32'd20, 32'd10}, {16'd16384, 16'd0}, 1'b0, 1'b0, 1'b0);
    idle(6);
    send({32'd100, 32'd50}, {32'd20, 32'd10}, {16'd0, 16'hC000}, 1'b0, 1'b0, 1'b0);
    send({32'd100, 32'd50}, {32'd20, 32'd10}, {16'd0, 16'h4000}, 1'b0, 1'b1, 1'b0);
    send({32'd100, 32'd50}, {32'd20, 32'd10}, {16'd0, 16'hC000}, 1'b1, 1'b0, 1'b0);
    send({32'h7FFF_FFF0, 32'd0}, {32'h20, 32'd0}, {16'd16384, 16'd0}, 1'b0, 1'b0, 1'b0);
    send({32'h7FFF_FFF0, 32'd0}, {32'h20, 32'd0}, {16'd16384, 16'd0}, 1'b0, 1'b0, 1'b1);
    send({32'h8000_0000, 32'h7FFF_FFFF}, {32'h7FFF_FFFF, 32'h8000_0000}, {16'h4000, 16'h8000}, 1'b1, 1'b1, 1'b0);
    idle(8);

    // streaming with alternating modes
    bus.in_valid = 1'b1;
    md = 1'b0;
    n_acc = 0;
    load_rand(md);
    for (int i = 0; i < 8; i++) begin
      tick(acc);
      if (acc) begin
        n_acc++;
        md = !md;
        load_rand(md);
      end
    end
    bus.in_valid = 1'b0;
    chk("stream_accepts", 64'(n_acc), 64'd4);
    idle(8);

    // reset with two results in flight
    send({32'd100, 32'd50}, {32'd20, 32'd10}, {16'd16384, 16'd0}, 1'b0, 1'b0, 1'b0);
    send({32'd100, 32'd50}, {32'd20, 32'd10}, {16'd0, 16'hC000}, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(6);
    send({32'd300, 32'hFFFF_FF00}, {32'd7, 32'd9}, {16'h2D41, 16'hD2BF}, 1'b0, 1'b0, 1'b0);
    idle(8);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      load_rand(1'($urandom));
      tick(acc);
    end
    bus.in_valid = 1'b0;
    idle(8);
    chk("drain", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
